// File: rtl/jk_cmd_seq.sv
// Command sequencer for jk_ff: buffers (op, len) commands in a small FIFO and plays each
// out as registered J/K levels held for len+1 cycles. Optional shadow checker: JK_CMD_SHADOW_EN.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef JK_CMD_SHADOW_EN
  input  logic                     q_fb,
  output logic                     q_exp,
  output logic                     mismatch,
`endif
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_len,
  output logic                     cmd_ready,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] len;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop, empty;
  cmd_t             head;

  state_t           state, state_d;
  logic [CNT_W-1:0] remain, remain_d;
  logic             j_d, k_d;

  assign empty     = (fifo_cnt == '0);
  assign cmd_ready = (fifo_cnt != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state == DRIVE);
  assign done      = (state == DRIVE) && (remain == '0);

  // NOTE: the storage array carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{op: cmd_op, len: cmd_len};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      remain <= '0;
      J      <= 1'b0;
      K      <= 1'b0;
    end else begin
      state  <= state_d;
      remain <= remain_d;
      J      <= j_d;
      K      <= k_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_d  = state;
    remain_d = remain;
    j_d      = J;
    k_d      = K;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          state_d  = DRIVE;
          j_d      = head.op[1];
          k_d      = head.op[0];
          remain_d = head.len;
        end
      end
      DRIVE: begin
        if (remain != '0) begin
          remain_d = remain - 1'b1;
        end else if (!empty) begin
          // Back-to-back: load the next command on the edge ending this one.
          pop      = 1'b1;
          j_d      = head.op[1];
          k_d      = head.op[0];
          remain_d = head.len;
        end else begin
          state_d = IDLE;
          j_d     = 1'b0;
          k_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef JK_CMD_SHADOW_EN
  // Shadow JK model driven by the same registered J/K the real flop sees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_exp    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
      if (busy && (q_fb != q_exp)) mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq (default build): table-driven vectors plus
// hand-written sequences for FIFO full, drain and asynchronous reset mid-drive.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             J, K, busy, done;
  logic [2:0]       fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .done      (done),
    .fifo_cnt  (fifo_cnt)
  );

  typedef struct {
    logic             valid;
    logic [1:0]       op;
    logic [CNT_W-1:0] len;
    logic [1:0]       jk;
    logic             busy;
    logic             done;
    logic [2:0]       cnt;
    logic             ready;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] len,
                              input logic [1:0] jk, input logic b, input logic d,
                              input logic [2:0] cnt);
    vec_t r;
    r.valid = v;   r.op = op;  r.len = len;
    r.jk    = jk;  r.busy = b; r.done = d;
    r.cnt   = cnt; r.ready = (cnt != 3'(DEPTH));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] len);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
  endtask

  initial begin
    int  cycles;
    int  dones;
    bit  seen;

    // Single set len=2, then back-to-back set/reset/toggle, then push+pop at count 2.
    vecs[0]  = mk(1, 2'b10, 4'd2, 2'b00, 0, 0, 3'd1);
    vecs[1]  = mk(0, 2'b00, 4'd0, 2'b10, 1, 0, 3'd0);
    vecs[2]  = mk(0, 2'b00, 4'd0, 2'b10, 1, 0, 3'd0);
    vecs[3]  = mk(0, 2'b00, 4'd0, 2'b10, 1, 1, 3'd0);
    vecs[4]  = mk(0, 2'b00, 4'd0, 2'b00, 0, 0, 3'd0);
    vecs[5]  = mk(1, 2'b10, 4'd0, 2'b00, 0, 0, 3'd1);
    vecs[6]  = mk(1, 2'b01, 4'd0, 2'b10, 1, 1, 3'd1);
    vecs[7]  = mk(1, 2'b11, 4'd1, 2'b01, 1, 1, 3'd1);
    vecs[8]  = mk(0, 2'b00, 4'd0, 2'b11, 1, 0, 3'd0);
    vecs[9]  = mk(0, 2'b00, 4'd0, 2'b11, 1, 1, 3'd0);
    vecs[10] = mk(0, 2'b00, 4'd0, 2'b00, 0, 0, 3'd0);
    vecs[11] = mk(1, 2'b11, 4'd1, 2'b00, 0, 0, 3'd1);
    vecs[12] = mk(1, 2'b01, 4'd0, 2'b11, 1, 0, 3'd1);
    vecs[13] = mk(1, 2'b10, 4'd0, 2'b11, 1, 1, 3'd2);
    vecs[14] = mk(1, 2'b00, 4'd0, 2'b01, 1, 1, 3'd2);
    vecs[15] = mk(0, 2'b00, 4'd0, 2'b10, 1, 1, 3'd1);
    vecs[16] = mk(0, 2'b00, 4'd0, 2'b00, 1, 1, 3'd0);
    vecs[17] = mk(0, 2'b00, 4'd0, 2'b00, 0, 0, 3'd0);

    rst = 1'b0;
    drive(0, 2'b00, '0);
    #2;
    check("rst.J", J, 0);
    check("rst.K", K, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.cnt", fifo_cnt, 0);
    check("rst.ready", cmd_ready, 1);
    step();
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].len);
      step();
      check($sformatf("vec%0d.JK", i), {J, K}, vecs[i].jk);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d.done", i), done, vecs[i].done);
      check($sformatf("vec%0d.cnt", i), fifo_cnt, vecs[i].cnt);
      check($sformatf("vec%0d.ready", i), cmd_ready, vecs[i].ready);
    end

    // Fill behind a 16-cycle toggle; fifth push must wait for the first pop.
    drive(1, 2'b11, 4'd15);
    step();
    check("full.cnt_e", fifo_cnt, 1);
    drive(0, 2'b00, '0);
    step();
    check("full.pop_e", {busy, J, K}, 3'b111);
    cycles = 1;
    drive(1, 2'b10, 4'd3); step(); cycles++; check("full.cnt1", fifo_cnt, 1);
    drive(1, 2'b01, 4'd0); step(); cycles++; check("full.cnt2", fifo_cnt, 2);
    drive(1, 2'b10, 4'd0); step(); cycles++; check("full.cnt3", fifo_cnt, 3);
    drive(1, 2'b11, 4'd0); step(); cycles++; check("full.cnt4", fifo_cnt, 4);
    check("full.ready0", cmd_ready, 0);
    drive(1, 2'b00, 4'd0);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      cycles++;
      check("full.hold_cnt", fifo_cnt, 4);
      check("full.hold_ready", cmd_ready, 0);
      if (done) seen = 1;
    end
    check("full.done_seen", seen, 1);
    check("full.e_cycles", cycles, 16);
    step();
    check("full.pop_cnt", fifo_cnt, 3);
    check("full.pop_ready", cmd_ready, 1);
    check("full.pop_JK", {J, K}, 2'b10);
    step();
    check("full.fifth_cnt", fifo_cnt, 4);
    check("full.fifth_ready", cmd_ready, 0);
    drive(0, 2'b00, '0);
    dones = 0;
    seen  = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      step();
      if (done) dones++;
      if (!busy) seen = 1;
    end
    check("drain.idle", seen, 1);
    check("drain.dones", dones, 5);
    check("drain.cnt", fifo_cnt, 0);
    check("drain.JK", {J, K}, 2'b00);

    // Asynchronous reset in the middle of a len=7 toggle with a command queued.
    drive(1, 2'b11, 4'd7);
    step();
    drive(1, 2'b10, 4'd3);
    step();
    drive(0, 2'b00, '0);
    step();
    step();
    check("mid.busy", busy, 1);
    check("mid.JK", {J, K}, 2'b11);
    #3;
    rst = 1'b0;
    #1;
    check("arst.JK", {J, K}, 2'b00);
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.cnt", fifo_cnt, 0);
    check("arst.ready", cmd_ready, 1);
    drive(1, 2'b10, 4'd1);
    step();
    check("arst.push_ign", fifo_cnt, 0);
    check("arst.busy_held", busy, 0);
    drive(0, 2'b00, '0);
    rst = 1'b1;
    step();
    check("post.busy", busy, 0);
    check("post.cnt", fifo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
